gty_refclk_freq_scan: RTL and testbench

Round-robin frequency scanner for the divided GTY reference clocks of banks 229–233. It samples N_CH slow divided clocks (`*_clk_div256`, about 0.3–0.7 MHz) as asynchronous data in the 100 MHz reference-clock domain. One shared edge counter is time-multiplexed across all channels, and each channel's rising-edge count is measured over a fixed gate window. Per-channel counts and pass/fail flags are stored and exposed through a readback port and a bitmask for LEDs/ILA.

---
 rtl/gty_clk_test_pkg.sv | 25 ++
 rtl/sync_edge_det.sv | 32 +++
 rtl/gty_refclk_freq_scan.sv | 130 +++++++++++++
 tb/tb_gty_refclk_freq_scan.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gty_clk_test_pkg.sv
// Shared types and constants for the GTY divided-refclk frequency scanner.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package gty_clk_test_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_GATE   = 2'd2,
    S_STORE  = 2'd3
  } scan_state_e;

  // Default pass window for a 1 ms gate on a ~0.3-0.7 MHz divided refclk.
  localparam int DEF_LO_LIMIT = 300;
  localparam int DEF_HI_LIMIT = 700;

  // Ceiling log2 with a floor of 1 so that single-entry selects keep a 1-bit port.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous bit, with a rising-edge strobe.
// Latency: q follows d after STAGES clk edges; rise is one cycle wide, aligned with q.
// Backpressure: none, free-running every cycle.
// Ports: clk, rst_n (async active-low); d async input; q synchronized level;
//        rise = q & ~q_delayed.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sr;
  logic              q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      q_d <= 1'b0;
    end else begin
      sr  <= {sr[STAGES-2:0], d};
      q_d <= sr[STAGES-1];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = q & ~q_d;

endmodule

// File: rtl/gty_refclk_freq_scan.sv
// Round-robin edge-count frequency scanner for N_CH divided GTY refclks.
// Latency: N_CH*(SETTLE_CYCLES+GATE_CYCLES+1) cycles per scan; readback 1 cycle.
// Backpressure: none; start while busy is dropped, cont is sampled only in IDLE.
// Ports: clk/rst_n; clk_div async inputs; start pulse / cont level; busy, done pulse;
//        rd_addr -> rd_data/rd_valid (registered); fail per-channel limit flags.
module gty_refclk_freq_scan
  import gty_clk_test_pkg::*;
#(
  parameter int N_CH          = 10,
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 16,
  parameter int LO_LIMIT      = DEF_LO_LIMIT,
  parameter int HI_LIMIT      = DEF_HI_LIMIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           clk_div,
  input  logic                      start,
  input  logic                      cont,
  output logic                      busy,
  output logic                      done,
  input  logic [clog2(N_CH)-1:0]    rd_addr,
  output logic [CNT_W-1:0]          rd_data,
  output logic                      rd_valid,
  output logic [N_CH-1:0]           fail
);

  localparam int AW = clog2(N_CH);
  // One phase timer serves both SETTLE and GATE, sized for the longer of the two.
  localparam int TW = clog2(((GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES) + 1);

  scan_state_e       state, state_nxt;
  logic [AW-1:0]     ch;
  logic [TW-1:0]     tmr;
  logic [CNT_W-1:0]  cnt;
  logic [N_CH-1:0]   sync_vec;
  logic [N_CH-1:0]   rise_unused;
  logic              sel, prev, rise;
  logic              settle_end, gate_end, last_ch;
  logic [CNT_W-1:0]  result [N_CH];
  logic [N_CH-1:0]   valid;
  logic              done_q;

  // Per-channel edge strobes are left unused: edges are detected after the mux so
  // that prev always tracks whichever channel is currently selected.
  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (clk_div[i]),
      .q    (sync_vec[i]),
      .rise (rise_unused[i])
    );
  end

  assign sel        = sync_vec[ch];
  assign rise       = sel & ~prev;
  assign settle_end = (tmr == TW'(SETTLE_CYCLES - 1));
  assign gate_end   = (tmr == TW'(GATE_CYCLES - 1));
  assign last_ch    = (ch == AW'(N_CH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start | cont) state_nxt = S_SETTLE;
      S_SETTLE: if (settle_end)   state_nxt = S_GATE;
      S_GATE:   if (gate_end)     state_nxt = S_STORE;
      S_STORE:  state_nxt = last_ch ? S_IDLE : S_SETTLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch       <= '0;
      tmr      <= '0;
      cnt      <= '0;
      prev     <= 1'b0;
      done_q   <= 1'b0;
      valid    <= '0;
      fail     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      for (int i = 0; i < N_CH; i++) result[i] <= '0;
    end else begin
      prev   <= sel;
      done_q <= (state == S_STORE) && last_ch;

      // Timer runs only inside SETTLE/GATE and restarts at every phase boundary.
      if ((state == S_SETTLE && !settle_end) || (state == S_GATE && !gate_end))
        tmr <= tmr + TW'(1);
      else
        tmr <= '0;

      case (state)
        S_IDLE:   ch <= '0;
        S_SETTLE: if (settle_end) cnt <= '0;
        S_GATE:   if (rise && (cnt != '1)) cnt <= cnt + CNT_W'(1);
        S_STORE: begin
          result[ch] <= cnt;
          valid[ch]  <= 1'b1;
          fail[ch]   <= (32'(cnt) < LO_LIMIT) || (32'(cnt) > HI_LIMIT);
          cnt        <= '0;
          if (!last_ch) ch <= ch + AW'(1);
        end
        default: ;
      endcase

      // Registered read: a STORE to the same address lands one cycle later.
      if (32'(rd_addr) < N_CH) begin
        rd_data  <= result[rd_addr];
        rd_valid <= valid[rd_addr];
      end else begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_gty_refclk_freq_scan.sv
// Self-checking bench for gty_refclk_freq_scan with randomized channel periods.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_gty_refclk_freq_scan;

  localparam int N_CH = 10;
  localparam int G    = 1000;
  localparam int S    = 4;
  localparam int LO   = 40;
  localparam int HI   = 60;
  localparam int AW   = 4;
  localparam int SCAN = N_CH * (S + G + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic [N_CH-1:0] clk_div;
  logic            start = 1'b0, cont = 1'b0;
  logic            busy, done, rd_valid;
  logic [AW-1:0]   rd_addr = '0;
  logic [15:0]     rd_data;
  logic [N_CH-1:0] fail;

  // narrow-counter instance for saturation
  logic [N_CH-1:0] clk_div_s;
  logic            start_s = 1'b0;
  logic            busy_s, done_s, rd_valid_s;
  logic [AW-1:0]   rd_addr_s = '0;
  logic [3:0]      rd_data_s;
  logic [N_CH-1:0] fail_s;

  gty_refclk_freq_scan #(
    .N_CH(N_CH), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .SYNC_STAGES(2),
    .CNT_W(16), .LO_LIMIT(LO), .HI_LIMIT(HI)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .start(start), .cont(cont),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .fail(fail)
  );

  gty_refclk_freq_scan #(
    .N_CH(N_CH), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .SYNC_STAGES(2),
    .CNT_W(4), .LO_LIMIT(LO), .HI_LIMIT(HI)
  ) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div_s), .start(start_s), .cont(1'b0),
    .busy(busy_s), .done(done_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
    .rd_valid(rd_valid_s), .fail(fail_s)
  );

  // Waveform generator: channel i is a square wave of period per[i] clk cycles
  // (0 = stuck low), changing on the falling clk edge.
  int per [N_CH];
  int ph  [N_CH];
  int ncyc = 0;
  always @(negedge clk) ncyc = ncyc + 1;

  for (genvar i = 0; i < N_CH; i++) begin : g_gen
    assign clk_div[i] = (per[i] > 0) ? (((ncyc + ph[i]) % per[i]) < (per[i] / 2)) : 1'b0;
  end
  assign clk_div_s = {{(N_CH-1){1'b0}}, ncyc[1]};  // period 4 on channel 0

  // Event monitor: records the clock number of busy edges and done pulses.
  int pcyc = 0;
  int done_q[$], brise_q[$], bfall_q[$];
  int done_s_cnt = 0;
  bit busy_d = 1'b0;
  always @(posedge clk) begin
    pcyc = pcyc + 1;
    #1;
    if (done) done_q.push_back(pcyc);
    if (done_s) done_s_cnt++;
    if (busy && !busy_d) brise_q.push_back(pcyc);
    if (!busy && busy_d) bfall_q.push_back(pcyc);
    busy_d = busy;
  end

  int tests = 0, failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int k;
    k = 0;
    while (done_q.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  // Reference: a W-cycle window of a period-P square wave holds W/P rising edges,
  // with the gate boundaries allowing one edge either way.
  function automatic void band(input int p, output int lo, output int hi);
    if (p == 0) begin
      lo = 0;
      hi = 0;
    end else begin
      lo = (G + p - 1) / p - 1;
      hi = G / p + 1;
    end
  endfunction

  task automatic randomize_periods();
    int ptab [15];
    ptab = '{4, 6, 8, 10, 12, 14, 16, 18, 20, 22, 24, 26, 30, 40, 0};
    for (int i = 0; i < N_CH; i++) begin
      per[i] = ptab[$urandom_range(0, 14)];
      ph[i]  = (per[i] > 0) ? $urandom_range(0, per[i] - 1) : 0;
    end
  endtask

  task automatic check_results(input string pfx);
    int lo, hi;
    bit in_lim, out_lim;
    for (int i = 0; i < N_CH; i++) begin
      rd_addr = AW'(i);
      tick();
      band(per[i], lo, hi);
      check_rng($sformatf("%s cnt ch%0d", pfx, i), int'(rd_data), lo, hi);
      check($sformatf("%s valid ch%0d", pfx, i), rd_valid, 1);
      in_lim  = (lo >= LO) && (hi <= HI);
      out_lim = (hi < LO) || (lo > HI);
      if (in_lim || out_lim)
        check($sformatf("%s fail ch%0d", pfx, i), fail[i], out_lim);
    end
  endtask

  initial begin
    int t0, mid, nd, nb;
    for (int i = 0; i < N_CH; i++) begin
      per[i] = 0;
      ph[i]  = 0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst fail", fail, 0);
    check("rst rd_data", rd_data, 0);
    check("rst rd_valid", rd_valid, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N_CH; i++) begin
      rd_addr = AW'(i);
      tick();
      check($sformatf("init valid ch%0d", i), rd_valid, 0);
      check($sformatf("init data ch%0d", i), rd_data, 0);
    end

    // Single scan with a second start mid-scan that must be ignored
    randomize_periods();
    per[0] = 20;
    per[3] = 0;
    per[5] = 10;
    start = 1'b1;
    start_s = 1'b1;
    t0 = pcyc;
    tick();
    start = 1'b0;
    start_s = 1'b0;
    mid = $urandom_range(100, 9000);
    repeat (mid) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_dones(1, SCAN + 50);
    repeat (20) tick();
    check("scan1 done count", done_q.size(), 1);
    check("scan1 busy rises", brise_q.size(), 1);
    check("scan1 busy rise time", qat(brise_q, 0), t0 + 1);
    check("scan1 done time", qat(done_q, 0) - qat(brise_q, 0), SCAN);
    check("scan1 busy width", qat(bfall_q, 0) - qat(brise_q, 0), SCAN);
    check_results("scan1");

    // Saturating instance
    rd_addr_s = 0;
    tick();
    check("sat cnt ch0", rd_data_s, 15);
    check("sat valid ch0", rd_valid_s, 1);
    check("sat fail ch0", fail_s[0], 1);
    rd_addr_s = 1;
    tick();
    check("sat cnt ch1", rd_data_s, 0);
    check("sat fail ch1", fail_s[1], 1);
    check("sat done pulses", done_s_cnt, 1);
    check("sat busy idle", busy_s, 0);

    // Reset during the GATE of channel 2
    rd_addr = 0;
    start = 1'b1;
    t0 = pcyc;
    tick();
    start = 1'b0;
    repeat (2 * (S + G + 1) + S + 300) tick();
    check("pre-rst busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid-rst busy", busy, 0);
    check("mid-rst done", done, 0);
    check("mid-rst fail", fail, 0);
    check("mid-rst rd_data", rd_data, 0);
    check("mid-rst rd_valid", rd_valid, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    nd = done_q.size();
    nb = brise_q.size();
    repeat (30) tick();
    check("post-rst no done", done_q.size(), nd);
    check("post-rst stays idle", brise_q.size(), nb);
    for (int i = 0; i < N_CH; i++) begin
      rd_addr = AW'(i);
      tick();
      check($sformatf("post-rst valid ch%0d", i), rd_valid, 0);
      check($sformatf("post-rst data ch%0d", i), rd_data, 0);
    end

    // Continuous mode: three full scans, drop cont during the fourth
    randomize_periods();
    done_q.delete();
    brise_q.delete();
    bfall_q.delete();
    cont = 1'b1;
    t0 = pcyc;
    wait_dones(3, 3 * (SCAN + 1) + 50);
    repeat (2000) tick();
    cont = 1'b0;
    wait_dones(4, SCAN + 100);
    repeat (50) tick();
    check("cont done count", done_q.size(), 4);
    check("cont busy rises", brise_q.size(), 4);
    check("cont first rise", qat(brise_q, 0), t0 + 1);
    check("cont first scan", qat(done_q, 0) - qat(brise_q, 0), SCAN);
    for (int j = 0; j < 4; j++)
      check($sformatf("cont busy fall %0d", j), qat(bfall_q, j), qat(done_q, j));
    for (int j = 1; j < 4; j++) begin
      check($sformatf("cont spacing %0d", j), qat(done_q, j) - qat(done_q, j - 1), SCAN + 1);
      check($sformatf("cont idle gap %0d", j), qat(brise_q, j), qat(done_q, j - 1) + 1);
    end
    check("cont final idle", busy, 0);
    check_results("cont");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
